conv_line_buffer: RTL and testbench

- Upstream feeder for the convolution MAC chain (the 17-bit signed y_in + x_in*w_in saturating stages).
- Accepts a raster stream of 8-bit unsigned pixels and buffers two previous image rows.
- Each cycle, emits three vertically aligned pixels (top/mid/bot) as 17-bit signed x operands for the column of MAC stages.
- Produces row/column border flags so downstream control can mask edge taps.

---
 rtl/conv_line_buffer_pkg.sv | 23 ++
 rtl/conv_line_buffer_if.sv | 26 ++
 rtl/conv_line_buffer_line_ram.sv | 25 ++
 rtl/conv_line_buffer.sv | 143 ++++++++++++++
 tb/tb_conv_line_buffer.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/conv_line_buffer_pkg.sv
// Shared types and constants for the line buffer and the MAC column it feeds.
package conv_line_buffer_pkg;

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned DATA_W = 17;

  // Saturation bounds of the downstream y_in + x_in*w_in stages.
  localparam logic [DATA_W-1:0] SAT_MAX = 17'h0ffff;
  localparam logic [DATA_W-1:0] SAT_MIN = 17'h10000;

  typedef enum logic [1:0] {
    IDLE,
    FILL0,
    FILL1,
    STREAM
  } lb_state_e;

  // Unsigned pixel to non-negative MAC operand.
  function automatic logic [DATA_W-1:0] zext_pix(input logic [PIX_W-1:0] pix);
    return {{(DATA_W - PIX_W){1'b0}}, pix};
  endfunction

endpackage

// File: rtl/conv_line_buffer_if.sv
// Pixel stream in, three-tap window out; master drives pixels, slave is the buffer.
interface conv_line_buffer_if;
  import conv_line_buffer_pkg::*;

  logic [PIX_W-1:0]  pix_in;
  logic              pix_valid;
  logic              sof;
  logic [DATA_W-1:0] x_top;
  logic [DATA_W-1:0] x_mid;
  logic [DATA_W-1:0] x_bot;
  logic              x_valid;
  logic              first_col;
  logic              last_col;
  logic              frame_done;

  modport master (
    output pix_in, pix_valid, sof,
    input  x_top, x_mid, x_bot, x_valid, first_col, last_col, frame_done
  );

  modport slave (
    input  pix_in, pix_valid, sof,
    output x_top, x_mid, x_bot, x_valid, first_col, last_col, frame_done
  );

endinterface

// File: rtl/conv_line_buffer_line_ram.sv
// Single-port line memory; a read and write at the same address in one cycle
// returns the old contents, which lets one row shift down into the next.
module line_ram #(
  parameter  int unsigned DEPTH  = 640,
  parameter  int unsigned WIDTH  = 8,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]  rd_data_c
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wr_data;
    end
  end

  assign rd_data_c = mem_q[addr];

endmodule

// File: rtl/conv_line_buffer.sv
// Two-row raster line buffer producing vertical 3-pixel windows with border flags
// for the convolution MAC column.
module conv_line_buffer
  import conv_line_buffer_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480
) (
  input logic               clk,
  input logic               rst,
  conv_line_buffer_if.slave lb
);

  localparam int unsigned COL_W = $clog2(IMG_WIDTH);
  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);

  lb_state_e         state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [DATA_W-1:0] x_top_q, x_top_d;
  logic [DATA_W-1:0] x_mid_q, x_mid_d;
  logic [DATA_W-1:0] x_bot_q, x_bot_d;
  logic              x_valid_q, x_valid_d;
  logic              first_col_q, first_col_d;
  logic              last_col_q, last_col_d;
  logic              frame_done_q, frame_done_d;

  logic              accept_c;
  logic              restart_c;
  logic              emit_c;
  logic              at_last_col_c;
  logic              at_last_row_c;
  logic [COL_W-1:0]  addr_c;
  logic [PIX_W-1:0]  l0_rd_c;
  logic [PIX_W-1:0]  l1_rd_c;

  // L1 holds the previous row; L0 takes L1's old word as it is overwritten.
  line_ram #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_l0 (
    .clk       (clk),
    .we        (accept_c),
    .addr      (addr_c),
    .wr_data   (l1_rd_c),
    .rd_data_c (l0_rd_c)
  );

  line_ram #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_l1 (
    .clk       (clk),
    .we        (accept_c),
    .addr      (addr_c),
    .wr_data   (lb.pix_in),
    .rd_data_c (l1_rd_c)
  );

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    x_top_d      = x_top_q;
    x_mid_d      = x_mid_q;
    x_bot_d      = x_bot_q;
    x_valid_d    = 1'b0;
    first_col_d  = 1'b0;
    last_col_d   = 1'b0;
    frame_done_d = 1'b0;

    // sof with a valid pixel always restarts at (0,0), aborting any frame.
    restart_c     = lb.pix_valid && lb.sof;
    accept_c      = lb.pix_valid && ((state_q != IDLE) || lb.sof);
    addr_c        = restart_c ? '0 : col_q;
    at_last_col_c = (addr_c == COL_W'(IMG_WIDTH - 1));
    at_last_row_c = (row_q == ROW_W'(IMG_HEIGHT - 1));
    emit_c        = accept_c && !restart_c && (state_q == STREAM);

    if (accept_c) begin
      if (restart_c) begin
        col_d   = COL_W'(1);
        row_d   = '0;
        state_d = FILL0;
      end else begin
        col_d = at_last_col_c ? '0 : col_q + COL_W'(1);
        if (at_last_col_c) begin
          row_d = row_q + ROW_W'(1);
        end
        unique case (state_q)
          FILL0:   if (at_last_col_c) state_d = FILL1;
          FILL1:   if (at_last_col_c) state_d = STREAM;
          STREAM: begin
            if (at_last_col_c && at_last_row_c) begin
              state_d = IDLE;
              row_d   = '0;
            end
          end
          default: state_d = state_q;
        endcase
      end
    end

    if (emit_c) begin
      x_top_d      = zext_pix(l0_rd_c);
      x_mid_d      = zext_pix(l1_rd_c);
      x_bot_d      = zext_pix(lb.pix_in);
      x_valid_d    = 1'b1;
      first_col_d  = (addr_c == '0);
      last_col_d   = at_last_col_c;
      frame_done_d = at_last_col_c && at_last_row_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      x_top_q      <= '0;
      x_mid_q      <= '0;
      x_bot_q      <= '0;
      x_valid_q    <= 1'b0;
      first_col_q  <= 1'b0;
      last_col_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      x_top_q      <= x_top_d;
      x_mid_q      <= x_mid_d;
      x_bot_q      <= x_bot_d;
      x_valid_q    <= x_valid_d;
      first_col_q  <= first_col_d;
      last_col_q   <= last_col_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign lb.x_top      = x_top_q;
  assign lb.x_mid      = x_mid_q;
  assign lb.x_bot      = x_bot_q;
  assign lb.x_valid    = x_valid_q;
  assign lb.first_col  = first_col_q;
  assign lb.last_col   = last_col_q;
  assign lb.frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_line_buffer.sv
// Randomized bench for conv_line_buffer against a frame-image reference model.
module tb_conv_line_buffer;
  import conv_line_buffer_pkg::*;

  localparam int unsigned IW   = 4;
  localparam int unsigned IH   = 4;
  localparam int unsigned NPIX = IW * IH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_line_buffer_if lb_if();

  conv_line_buffer #(.IMG_WIDTH(IW), .IMG_HEIGHT(IH)) dut (
    .clk (clk),
    .rst (rst),
    .lb  (lb_if)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: the image as written so far, plus position within the frame.
  logic [7:0]        img [IH][IW];
  bit                in_frame = 1'b0;
  int                pos      = 0;
  logic [DATA_W-1:0] e_top, e_mid, e_bot;
  logic              e_valid, e_first, e_last, e_done;
  int                win_cnt, done_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_outputs();
    check("x_top",      32'(lb_if.x_top),      32'(e_top));
    check("x_mid",      32'(lb_if.x_mid),      32'(e_mid));
    check("x_bot",      32'(lb_if.x_bot),      32'(e_bot));
    check("x_valid",    32'(lb_if.x_valid),    32'(e_valid));
    check("first_col",  32'(lb_if.first_col),  32'(e_first));
    check("last_col",   32'(lb_if.last_col),   32'(e_last));
    check("frame_done", 32'(lb_if.frame_done), 32'(e_done));
  endtask

  task automatic model_reset();
    in_frame = 1'b0;
    pos      = 0;
    e_top = '0; e_mid = '0; e_bot = '0;
    e_valid = 1'b0; e_first = 1'b0; e_last = 1'b0; e_done = 1'b0;
  endtask

  // One clock: predict, drive, then compare outputs just after the edge.
  task automatic step(input logic v, input logic s, input logic [7:0] p);
    int r, c;
    e_valid = 1'b0; e_first = 1'b0; e_last = 1'b0; e_done = 1'b0;
    if (v && (in_frame || s)) begin
      if (s) begin
        pos      = 0;
        in_frame = 1'b1;
      end
      r = pos / IW;
      c = pos % IW;
      img[r][c] = p;
      if (r >= 2 && !s) begin
        e_top   = DATA_W'(img[r-2][c]);
        e_mid   = DATA_W'(img[r-1][c]);
        e_bot   = DATA_W'(p);
        e_valid = 1'b1;
        e_first = (c == 0);
        e_last  = (c == IW - 1);
        e_done  = (pos == NPIX - 1);
      end
      pos++;
      if (pos == NPIX) in_frame = 1'b0;
    end
    lb_if.pix_valid = v;
    lb_if.sof       = s;
    lb_if.pix_in    = p;
    @(posedge clk);
    #1;
    check_outputs();
    if (lb_if.x_valid)    win_cnt++;
    if (lb_if.frame_done) done_cnt++;
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    lb_if.pix_valid = 1'b0;
    lb_if.sof       = 1'b0;
    lb_if.pix_in    = '0;
    @(posedge clk);
    #1;
    model_reset();
    check_outputs();
    rst = 1'b0;
  endtask

  task automatic bubbles(input int pct);
    for (int k = 0; k < 3; k++) begin
      if (int'($urandom_range(99)) < pct)
        step(1'b0, 1'($urandom_range(1)), 8'($urandom));
    end
  endtask

  // Ramp frame, pixel = 16*row+col; optional bubbles in rows 1-3 and a 0xFF tap.
  task automatic ramp_frame(input int pct, input int stop_at, input int ff_at, input bit explicit_chk);
    logic [7:0] p;
    for (int i = 0; i < stop_at; i++) begin
      if (i >= int'(IW)) bubbles(pct);
      p = (i == ff_at) ? 8'hFF : 8'(16 * (i / IW) + i % IW);
      step(1'b1, i == 0, p);
      if (explicit_chk && i == 9) begin
        check("w21_top", 32'(lb_if.x_top), 32'h01);
        check("w21_mid", 32'(lb_if.x_mid), 32'h11);
        check("w21_bot", 32'(lb_if.x_bot), 32'h21);
        check("w21_flags", {29'd0, lb_if.x_valid, lb_if.first_col, lb_if.last_col}, 32'h4);
      end
      if (explicit_chk && i == 15) begin
        check("w33_top", 32'(lb_if.x_top), 32'h13);
        check("w33_mid", 32'(lb_if.x_mid), 32'h23);
        check("w33_bot", 32'(lb_if.x_bot), 32'h33);
        check("w33_flags", {29'd0, lb_if.last_col, lb_if.frame_done, lb_if.x_valid}, 32'h7);
      end
      if (i == ff_at) check("ff_zext", 32'(lb_if.x_bot), 32'h000FF);
    end
  endtask

  initial begin
    rst             = 1'b1;
    lb_if.pix_valid = 1'b0;
    lb_if.sof       = 1'b0;
    lb_if.pix_in    = '0;

    // Reset then a gap-free frame, followed by sof-less pixels in IDLE.
    do_reset();
    win_cnt = 0; done_cnt = 0;
    ramp_frame(0, NPIX, -1, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 8'h5A);
    check("win_cnt_s1", 32'(win_cnt), 32'd8);
    check("done_cnt_s1", 32'(done_cnt), 32'd1);

    // Same frame with random bubbles.
    win_cnt = 0; done_cnt = 0;
    ramp_frame(40, NPIX, -1, 1'b1);
    check("win_cnt_bub", 32'(win_cnt), 32'd8);
    check("done_cnt_bub", 32'(done_cnt), 32'd1);

    // sof at (3,1) aborts; the new frame restarts cleanly.
    win_cnt = 0; done_cnt = 0;
    ramp_frame(0, 13, -1, 1'b0);
    step(1'b1, 1'b1, 8'h00);
    check("abort_no_win", 32'(lb_if.x_valid), 32'd0);
    for (int i = 1; i < int'(NPIX); i++) begin
      step(1'b1, 1'b0, 8'(16 * (i / IW) + i % IW));
      if (i == 8) begin
        check("new_top", 32'(lb_if.x_top), 32'h00);
        check("new_mid", 32'(lb_if.x_mid), 32'h10);
        check("new_bot", 32'(lb_if.x_bot), 32'h20);
      end
    end
    check("win_cnt_abort", 32'(win_cnt), 32'd13);
    check("done_cnt_abort", 32'(done_cnt), 32'd1);

    // Full-scale pixel stays non-negative.
    ramp_frame(0, NPIX, 10, 1'b0);

    // Reset in STREAM, then the first scenario again.
    ramp_frame(0, 11, -1, 1'b0);
    do_reset();
    win_cnt = 0; done_cnt = 0;
    ramp_frame(0, NPIX, -1, 1'b1);
    check("win_cnt_rst", 32'(win_cnt), 32'd8);
    check("done_cnt_rst", 32'(done_cnt), 32'd1);

    // Random traffic: random pixels, bubbles, stray and mid-frame sof.
    for (int n = 0; n < 600; n++) begin
      logic v, s;
      v = ($urandom_range(99) < 75);
      s = (n % 40 == 0) || ($urandom_range(99) < 3);
      step(v, s, 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
